// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small in-order queue toward decode.
// Optional build macro FETCH_BYPASS_EN: a response arriving into an empty
// queue is presented to decode in the same cycle (request-to-valid latency 1).
// Without it every response is written to the queue first (latency 2).
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        imem_req_o,
   output logic [ADDR_W-1:0]           imem_addr_o,
   input  logic [INST_W-1:0]           imem_inst,
   input  logic                        jump,
   input  logic [ADDR_W-1:0]           jump_addr,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [INST_W-1:0]           inst_o,
   output logic [ADDR_W-1:0]           inst_addr_o,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] resp_addr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic              inflight_q;
   logic              stale_q;

   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];

   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [PTR_W-1:0]  count;
   logic [PTR_W:0]    occ;
   logic              empty;
   logic              full;
   logic              resp_valid;
   logic              valid_c;
   logic              xfer;
   logic              enq;
   logic              deq;
   logic              req;
   logic [INST_W-1:0] head_inst;
   logic [ADDR_W-1:0] head_addr;

   // Queue status from wrap-bit pointers
   always_comb begin
      wr_idx = wr_ptr_q[IDX_W-1:0];
      rd_idx = rd_ptr_q[IDX_W-1:0];
      count  = wr_ptr_q - rd_ptr_q;
      empty  = (wr_ptr_q == rd_ptr_q);
      full   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) && (wr_idx == rd_idx);
   end

   // Head selection, handshake, enqueue/dequeue and request decision
   always_comb begin
      resp_valid = ~rst & inflight_q & ~stale_q;
`ifdef FETCH_BYPASS_EN
      valid_c   = ~empty | resp_valid;
      head_inst = empty ? imem_inst   : inst_mem[rd_idx];
      head_addr = empty ? resp_addr_q : addr_mem[rd_idx];
      xfer      = valid_c & ready_i & ~jump;
      deq       = xfer & ~empty;
      enq       = resp_valid & ~jump & ~(empty & ready_i) & (~full | deq);
`else
      valid_c   = ~empty;
      head_inst = inst_mem[rd_idx];
      head_addr = addr_mem[rd_idx];
      xfer      = valid_c & ready_i & ~jump;
      deq       = xfer;
      enq       = resp_valid & ~jump & (~full | deq);
`endif
      occ = (PTR_W+1)'(count) + (PTR_W+1)'(resp_valid) - (PTR_W+1)'(xfer);
      req = ~rst & ~jump & (occ < (PTR_W+1)'(DEPTH));
   end

   // Output drive; everything is forced to zero while in reset
   always_comb begin
      imem_req_o  = req;
      imem_addr_o = rst ? '0 : pc_q;
      valid_o     = ~rst & valid_c;
      inst_o      = valid_o ? head_inst : '0;
      inst_addr_o = valid_o ? head_addr : '0;
      count_o     = rst ? '0 : count;
   end

   // Control state: pc, pointers, inflight and stale tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         resp_addr_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         inflight_q  <= 1'b0;
         stale_q     <= 1'b0;
      end else if (jump) begin
         pc_q       <= jump_addr;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
         stale_q    <= 1'b1;
      end else begin
         stale_q    <= 1'b0;
         inflight_q <= req;
         if (req) begin
            pc_q        <= pc_q + ADDR_W'(4);
            resp_addr_q <= pc_q;
         end
         if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Queue storage, written with the response and its request address
   always_ff @(posedge clk) begin
      if (enq) begin
         inst_mem[wr_idx] <= imem_inst;
         addr_mem[wr_idx] <= resp_addr_q;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with a one-cycle memory model.
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_inst;
   logic        jump;
   logic [31:0] jump_addr;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic [2:0]  count_o;

   int checks   = 0;
   int failures = 0;
   int nreq;

   fetch_queue dut (
      .clk(clk), .rst(rst),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_inst(imem_inst),
      .jump(jump), .jump_addr(jump_addr),
      .valid_o(valid_o), .ready_i(ready_i),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Memory answers exactly one cycle after a request; garbage otherwise
   always @(posedge clk)
      imem_inst <= imem_req_o ? mem_data(imem_addr_o) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, apply inputs for it, let combinational outputs settle
   task automatic cyc(input logic r, input logic rd, input logic j, input logic [31:0] ja);
      @(posedge clk);
      #2;
      rst = r; ready_i = rd; jump = j; jump_addr = ja;
      #1;
   endtask

   initial begin
      rst = 1'b1; ready_i = 1'b1; jump = 1'b0; jump_addr = '0;

      // reset state
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk("rst_req",   64'(imem_req_o), 64'(0));
      chk("rst_valid", 64'(valid_o), 64'(0));
      chk("rst_count", 64'(count_o), 64'(0));
      chk("rst_inst",  64'(inst_o), 64'(0));
      chk("rst_iaddr", 64'(inst_addr_o), 64'(0));

      // streaming with ready_i=1: sequential addresses, fixed latency
      for (int n = 1; n <= 6; n++) begin
         cyc(0, 1, 0, 0);
         chk("s_req",  64'(imem_req_o), 64'(1));
         chk("s_addr", 64'(imem_addr_o), 64'(4 * (n - 1)));
         chk("s_count", 64'(count_o), 64'((LAT == 2 && n >= 3) ? 1 : 0));
         if (n > LAT) begin
            chk("s_valid", 64'(valid_o), 64'(1));
            chk("s_iaddr", 64'(inst_addr_o), 64'(4 * (n - 1 - LAT)));
            chk("s_inst",  64'(inst_o), 64'(mem_data(32'(4 * (n - 1 - LAT)))));
         end else begin
            chk("s_valid0", 64'(valid_o), 64'(0));
         end
      end

      // fill with ready_i=0: exactly DEPTH requests, head held at address 0
      cyc(1, 0, 0, 0);
      chk("r2_count", 64'(count_o), 64'(0));
      chk("r2_req",   64'(imem_req_o), 64'(0));
      nreq = 0;
      for (int n = 1; n <= 8; n++) begin
         cyc(0, 0, 0, 0);
         if (imem_req_o) nreq++;
         chk("f_count", 64'(count_o), 64'((n <= 2) ? 0 : ((n >= 6) ? 4 : n - 2)));
         if (n >= 3) begin
            chk("f_iaddr", 64'(inst_addr_o), 64'(0));
            chk("f_inst",  64'(inst_o), 64'(mem_data(32'h0)));
         end
      end
      chk("f_nreq", 64'(nreq), 64'(4));
      chk("f_req0", 64'(imem_req_o), 64'(0));

      // full queue, one accept: refetch at 16 and refill to 4
      cyc(0, 1, 0, 0);
      chk("fa_req",   64'(imem_req_o), 64'(1));
      chk("fa_addr",  64'(imem_addr_o), 64'(16));
      chk("fa_count", 64'(count_o), 64'(4));
      chk("fa_iaddr", 64'(inst_addr_o), 64'(0));
      cyc(0, 0, 0, 0);
      chk("fb_req",   64'(imem_req_o), 64'(0));
      chk("fb_count", 64'(count_o), 64'(3));
      chk("fb_iaddr", 64'(inst_addr_o), 64'(4));
      cyc(0, 0, 0, 0);
      chk("fc_count", 64'(count_o), 64'(4));
      chk("fc_req",   64'(imem_req_o), 64'(0));

      // jump with an inflight request, then a second jump: last one wins
      cyc(0, 1, 0, 0);
      chk("j_pre_req",  64'(imem_req_o), 64'(1));
      chk("j_pre_addr", 64'(imem_addr_o), 64'(20));
      cyc(0, 1, 1, 32'h200);
      chk("j1_req", 64'(imem_req_o), 64'(0));
      cyc(0, 1, 1, 32'h100);
      chk("j2_req",   64'(imem_req_o), 64'(0));
      chk("j2_count", 64'(count_o), 64'(0));
      chk("j2_valid", 64'(valid_o), 64'(0));
      cyc(0, 0, 0, 0);
      chk("ja_valid", 64'(valid_o), 64'(0));
      chk("ja_count", 64'(count_o), 64'(0));
      chk("ja_req",   64'(imem_req_o), 64'(1));
      chk("ja_addr",  64'(imem_addr_o), 64'(32'h100));
      cyc(0, 0, 0, 0);
      chk("jb_addr",  64'(imem_addr_o), 64'(32'h104));
      chk("jb_count", 64'(count_o), 64'(0));
      cyc(0, 0, 0, 0);
      chk("jc_valid", 64'(valid_o), 64'(1));
      chk("jc_iaddr", 64'(inst_addr_o), 64'(32'h100));
      chk("jc_inst",  64'(inst_o), 64'(mem_data(32'h100)));
      chk("jc_count", 64'(count_o), 64'(1));

      // reset pulse mid-operation with three entries stored
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("m_count3", 64'(count_o), 64'(3));
      cyc(1, 0, 0, 0);
      chk("m_rst_req",   64'(imem_req_o), 64'(0));
      chk("m_rst_valid", 64'(valid_o), 64'(0));
      chk("m_rst_count", 64'(count_o), 64'(0));
      chk("m_rst_inst",  64'(inst_o), 64'(0));
      chk("m_rst_iaddr", 64'(inst_addr_o), 64'(0));
      cyc(0, 0, 0, 0);
      chk("m_count", 64'(count_o), 64'(0));
      chk("m_valid", 64'(valid_o), 64'(0));
      chk("m_req",   64'(imem_req_o), 64'(1));
      chk("m_addr",  64'(imem_addr_o), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
